ex_mdu: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Accepts an operation and two operands from the decode/issue side through a valid/ready handshake.
- Iterates one bit per cycle: shift-add multiply, restoring divide.
- Returns a one-cycle result pulse to writeback. The pipeline stalls on md_busy_o.

---
 rtl/ex_mdu.sv | 142 ++++++++++++++
 tb/tb_ex_mdu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit; shift-add multiply and restoring
// divide at one bit per cycle, with a single-cycle result strobe to writeback.
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            md_valid_i,
    output logic            md_ready_o,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] md_a_data_i,
    input  logic [XLEN-1:0] md_b_data_i,
    input  logic            md_flush_i,
    output logic            md_busy_o,
    output logic            md_valid_o,
    output logic [XLEN-1:0] md_data_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_spec;
    logic            r_valid;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_data;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_spec;
    logic [XLEN-1:0]   w_spec_val;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shr;
    logic [XLEN+1:0]   w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;

    assign md_ready_o = (r_state == S_IDLE);
    assign md_busy_o  = (r_state != S_IDLE);
    assign md_valid_o = r_valid;
    assign md_data_o  = r_data;

    // Flush wins over a new request arriving in IDLE
    assign w_accept = md_valid_i && (r_state == S_IDLE) && !md_flush_i;

    assign w_a_neg = md_a_data_i[XLEN-1] && (md_op_i == 3'd1 || md_op_i == 3'd2 ||
                                             md_op_i == 3'd4 || md_op_i == 3'd6);
    assign w_b_neg = md_b_data_i[XLEN-1] && (md_op_i == 3'd1 || md_op_i == 3'd4 ||
                                             md_op_i == 3'd6);
    assign w_a_mag = w_a_neg ? -md_a_data_i : md_a_data_i;
    assign w_b_mag = w_b_neg ? -md_b_data_i : md_b_data_i;

    assign w_div0     = (md_b_data_i == '0);
    assign w_ovf      = !md_op_i[0] && (md_a_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (&md_b_data_i);
    assign w_spec     = md_op_i[2] && (w_div0 || w_ovf);
    assign w_spec_val = w_div0 ? (md_op_i[1] ? md_a_data_i : {XLEN{1'b1}})
                               : (md_op_i[1] ? {XLEN{1'b0}} : md_a_data_i);

    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_shr  = {r_hi, r_lo[XLEN-1]};
    assign w_diff = {1'b0, w_shr} - {2'b00, r_opb};
    assign w_ge   = !w_diff[XLEN+1];

    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg_q ? -r_lo : r_lo;
    assign w_rem  = r_neg_r ? -r_hi : r_hi;
    assign w_res  = r_spec          ? r_lo :
                    (r_op == 3'd0)  ? w_prod[XLEN-1:0] :
                    !r_op[2]        ? w_prod[2*XLEN-1:XLEN] :
                    !r_op[1]        ? w_quo : w_rem;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_spec  <= 1'b0;
            r_valid <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= md_op_i;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_spec  <= w_spec;
                    r_cnt   <= CW'(XLEN);
                    r_hi    <= '0;
                    r_lo    <= w_spec ? w_spec_val : (md_op_i[2] ? w_a_mag : w_b_mag);
                    r_opb   <= md_op_i[2] ? w_b_mag : w_a_mag;
                    r_state <= w_spec ? S_FIX : S_CALC;
                end
                S_CALC: if (md_flush_i) begin
                    r_state <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                    // r_hi/r_lo hold product halves or remainder/quotient
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shr[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= md_flush_i ? S_IDLE : S_DONE;
                    if (!md_flush_i) r_lo <= w_res;
                end
                default: begin
                    r_state <= S_IDLE;
                    if (!md_flush_i) begin
                        r_valid <= 1'b1;
                        r_data  <= r_lo;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized and directed checks of ex_mdu against a plain-arithmetic
// RV32M reference model, including latency, flush and async reset behaviour.
module tb_ex_mdu;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        md_valid_i = 1'b0;
    logic        md_flush_i = 1'b0;
    logic [2:0]  md_op_i = '0;
    logic [31:0] md_a_data_i = '0;
    logic [31:0] md_b_data_i = '0;
    logic        md_ready_o;
    logic        md_busy_o;
    logic        md_valid_o;
    logic [31:0] md_data_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] last_data = '0;

    always #5 clk_i = ~clk_i;

    ex_mdu #(.XLEN(32)) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .md_valid_i(md_valid_i),
        .md_ready_o(md_ready_o),
        .md_op_i(md_op_i),
        .md_a_data_i(md_a_data_i),
        .md_b_data_i(md_b_data_i),
        .md_flush_i(md_flush_i),
        .md_busy_o(md_busy_o),
        .md_valid_o(md_valid_o),
        .md_data_o(md_data_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        int sa;
        int sb;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int k;
        int n_low;
        exp = ref_md(op, a, b);
        lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 34;
        @(negedge clk_i);
        md_op_i = op;
        md_a_data_i = a;
        md_b_data_i = b;
        md_valid_i = 1'b1;
        @(posedge clk_i);
        #1 md_valid_i = 1'b0;
        k = 0;
        n_low = 0;
        while (!md_valid_o && k < 100) begin
            if (!md_ready_o) n_low++;
            @(posedge clk_i);
            #1 k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(lat));
        check({tag, "_ready_low"}, 32'(n_low), 32'(lat));
        check({tag, "_data"}, md_data_o, exp);
        last_data = exp;
        @(posedge clk_i);
        #1 check({tag, "_pulse"}, {31'd0, md_valid_o}, 32'd0);
    endtask

    initial begin
        int seen;
        #1;
        check("rst_ready", {31'd0, md_ready_o}, 32'd1);
        check("rst_busy", {31'd0, md_busy_o}, 32'd0);
        check("rst_valid", {31'd0, md_valid_o}, 32'd0);
        check("rst_data", md_data_o, 32'd0);
        #20 rst_n_i = 1'b1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 3'd5, 32'd100, 32'd7);
        run_op("remu", 3'd7, 32'd100, 32'd7);
        run_op("div0", 3'd4, 32'd5, 32'd0);
        run_op("remu0", 3'd7, 32'd5, 32'd0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // request with flush in IDLE is dropped
        @(negedge clk_i);
        md_op_i = 3'd0;
        md_a_data_i = 32'd2;
        md_b_data_i = 32'd2;
        md_valid_i = 1'b1;
        md_flush_i = 1'b1;
        @(posedge clk_i);
        #1 md_valid_i = 1'b0;
        md_flush_i = 1'b0;
        check("idle_flush_ready", {31'd0, md_ready_o}, 32'd1);

        // flush at cycle 10 of a divide
        @(negedge clk_i);
        md_op_i = 3'd4;
        md_a_data_i = 32'd100;
        md_b_data_i = 32'd7;
        md_valid_i = 1'b1;
        @(posedge clk_i);
        #1 md_valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        md_flush_i = 1'b1;
        @(posedge clk_i);
        #1 md_flush_i = 1'b0;
        check("flush_busy", {31'd0, md_busy_o}, 32'd0);
        check("flush_ready", {31'd0, md_ready_o}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1 if (md_valid_o) seen++;
        end
        check("flush_novalid", 32'(seen), 32'd0);
        check("flush_data", md_data_o, last_data);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4);

        // asynchronous reset between edges in CALC
        @(negedge clk_i);
        md_op_i = 3'd5;
        md_a_data_i = 32'd1000;
        md_b_data_i = 32'd3;
        md_valid_i = 1'b1;
        @(posedge clk_i);
        #1 md_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        check("arst_busy", {31'd0, md_busy_o}, 32'd0);
        check("arst_ready", {31'd0, md_ready_o}, 32'd1);
        check("arst_valid", {31'd0, md_valid_o}, 32'd0);
        check("arst_data", md_data_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_op("divu_after_rst", 3'd5, 32'd9, 32'd3);

        for (int i = 0; i < 60; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
